// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pcgen_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FLUSH = 2'd1,
    BR    = 2'd2,
    PRED  = 2'd3
  } redirect_src_e;

  localparam logic [63:0] FETCH_RESET_VECTOR = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/fetch_lane_mask.sv
// Bundle alignment: aligned base of a PC and the lane-valid mask for an unaligned start.
module fetch_lane_mask #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic [XLEN-1:0]        pc,
  output logic [FETCH_WIDTH-1:0] mask,
  output logic [XLEN-1:0]        base
);

  localparam int unsigned B_BYTES = FETCH_WIDTH * INSTR_BYTES;
  localparam int unsigned IB_LG   = $clog2(INSTR_BYTES);

  logic [XLEN-1:0] off;

  assign off  = (pc >> IB_LG) & XLEN'(FETCH_WIDTH - 1);
  assign base = pc & ~XLEN'(B_BYTES - 1);

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      mask[i] = (XLEN'(i) >= off);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: redirect arbitration, sequential advance, debug halt and I-cache handshake.
module pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned         XLEN         = 64,
  parameter int unsigned         FETCH_WIDTH  = 2,
  parameter int unsigned         INSTR_BYTES  = 4,
  parameter int unsigned         EPOCH_W      = 4,
  parameter logic [XLEN-1:0]     RESET_VECTOR = XLEN'(FETCH_RESET_VECTOR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_valid_i,
  input  logic [XLEN-1:0]        flush_pc_i,
  input  logic [EPOCH_W-1:0]     flush_id_i,
  input  logic                   br_valid_i,
  input  logic [XLEN-1:0]        br_target_i,
  input  logic                   pred_valid_i,
  input  logic [XLEN-1:0]        pred_target_i,
  input  logic                   halt_i,
  input  logic                   resume_i,
  input  logic                   fetch_ready_i,
  output logic                   fetch_valid_o,
  output logic [XLEN-1:0]        fetch_pc_o,
  output logic [FETCH_WIDTH-1:0] fetch_mask_o,
  output logic [EPOCH_W-1:0]     fetch_epoch_o,
  output logic [XLEN-1:0]        next_pc_o,
  output logic                   redirect_o
);

  localparam int unsigned B_BYTES = FETCH_WIDTH * INSTR_BYTES;

  pcgen_state_e    state_q;
  redirect_src_e   src;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] tgt_aligned;
  logic [EPOCH_W-1:0] epoch_q;
  logic            valid_q;
  logic            redirect_q;
  logic            fire;

  fetch_lane_mask #(
    .XLEN        (XLEN),
    .FETCH_WIDTH (FETCH_WIDTH),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_lane_mask (
    .pc   (pc_q),
    .mask (fetch_mask_o),
    .base (base)
  );

  assign next_pc_o   = base + XLEN'(B_BYTES);
  assign fire        = valid_q & fetch_ready_i;
  assign tgt_aligned = tgt & ~XLEN'(INSTR_BYTES - 1);

  // Redirect arbitration: flush > branch > predictor; nothing redirects during BOOT.
  always_comb begin
    src = NONE;
    tgt = pc_q;
    if (state_q != BOOT) begin
      if (flush_valid_i) begin
        src = FLUSH;
        tgt = flush_pc_i;
      end else if (br_valid_i) begin
        src = BR;
        tgt = br_target_i;
      end else if (pred_valid_i) begin
        src = PRED;
        tgt = pred_target_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epoch_q    <= '0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= (src != NONE);

      case (src)
        FLUSH: begin
          pc_q    <= tgt_aligned;
          epoch_q <= flush_id_i;
        end
        BR: begin
          pc_q    <= tgt_aligned;
          epoch_q <= epoch_q + EPOCH_W'(1);
        end
        PRED: pc_q <= tgt_aligned;
        default: if (fire) pc_q <= next_pc_o;
      endcase

      // valid tracks the state it is entering so it stays a flop output.
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (halt_i) begin
            state_q <= HALT;
            valid_q <= 1'b0;
          end
        end
        HALT: begin
          if (resume_i) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid_o = valid_q;
  assign fetch_pc_o    = pc_q;
  assign fetch_epoch_o = epoch_q;
  assign redirect_o    = redirect_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: two instances (2- and 4-wide) against a behavioural model.
module tb_pc_gen;

  localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush_valid, br_valid, pred_valid, halt, resume, ready;
  logic [63:0] flush_pc, br_target, pred_target;
  logic [3:0]  flush_id;

  logic        v2, rd2, v4, rd4;
  logic [63:0] pc2, np2, pc4, np4;
  logic [1:0]  mask2;
  logic [3:0]  mask4, ep2, ep4;

  pc_gen #(.FETCH_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .flush_valid_i(flush_valid), .flush_pc_i(flush_pc), .flush_id_i(flush_id),
    .br_valid_i(br_valid), .br_target_i(br_target),
    .pred_valid_i(pred_valid), .pred_target_i(pred_target),
    .halt_i(halt), .resume_i(resume), .fetch_ready_i(ready),
    .fetch_valid_o(v2), .fetch_pc_o(pc2), .fetch_mask_o(mask2),
    .fetch_epoch_o(ep2), .next_pc_o(np2), .redirect_o(rd2)
  );

  pc_gen #(.FETCH_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .flush_valid_i(flush_valid), .flush_pc_i(flush_pc), .flush_id_i(flush_id),
    .br_valid_i(br_valid), .br_target_i(br_target),
    .pred_valid_i(pred_valid), .pred_target_i(pred_target),
    .halt_i(halt), .resume_i(resume), .fetch_ready_i(ready),
    .fetch_valid_o(v4), .fetch_pc_o(pc4), .fetch_mask_o(mask4),
    .fetch_epoch_o(ep4), .next_pc_o(np4), .redirect_o(rd4)
  );

  int vectors = 0;
  int fails   = 0;

  // Model state per instance: 0 = 2-wide, 1 = 4-wide. mode: 0 boot, 1 run, 2 halt.
  logic [63:0] m_pc [2];
  logic [3:0]  m_ep [2];
  logic        m_val[2];
  logic        m_red[2];
  int          m_mode[2];

  function automatic int fw_of(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_mask(logic [63:0] pc, int fw);
    int b   = fw * 4;
    int off = int'(pc % 64'(b)) / 4;
    int m   = ((1 << fw) - 1) & ~((1 << off) - 1);
    return 4'(m);
  endfunction

  function automatic logic [63:0] exp_next(logic [63:0] pc, int fw);
    logic [63:0] b = 64'(fw * 4);
    return pc - (pc % b) + b;
  endfunction

  task automatic model_update(int k);
    logic [63:0] npc;
    if (rst) begin
      m_mode[k] = 0; m_pc[k] = RV; m_ep[k] = 4'd0; m_val[k] = 1'b0; m_red[k] = 1'b0;
    end else begin
      npc = m_pc[k];
      m_red[k] = 1'b0;
      if (m_mode[k] != 0 && flush_valid) begin
        npc = flush_pc & ~64'd3; m_ep[k] = flush_id; m_red[k] = 1'b1;
      end else if (m_mode[k] != 0 && br_valid) begin
        npc = br_target & ~64'd3; m_ep[k] = 4'((int'(m_ep[k]) + 1) % 16); m_red[k] = 1'b1;
      end else if (m_mode[k] != 0 && pred_valid) begin
        npc = pred_target & ~64'd3; m_red[k] = 1'b1;
      end else if (m_val[k] && ready) begin
        npc = exp_next(m_pc[k], fw_of(k));
      end
      m_pc[k] = npc;
      if (m_mode[k] == 0) m_mode[k] = 1;
      else if (m_mode[k] == 1 && halt) m_mode[k] = 2;
      else if (m_mode[k] == 2 && resume) m_mode[k] = 1;
      m_val[k] = (m_mode[k] == 1);
    end
  endtask

  task automatic check_model();
    logic        ov, ord;
    logic [63:0] opc, onp;
    logic [3:0]  om, oep;
    for (int k = 0; k < 2; k++) begin
      ov  = (k == 0) ? v2  : v4;
      ord = (k == 0) ? rd2 : rd4;
      opc = (k == 0) ? pc2 : pc4;
      onp = (k == 0) ? np2 : np4;
      om  = (k == 0) ? {2'b00, mask2} : mask4;
      oep = (k == 0) ? ep2 : ep4;
      vectors += 6;
      assert (ov === m_val[k]) else begin fails++; $error("FAIL valid w%0d got %0b want %0b", fw_of(k), ov, m_val[k]); end
      assert (opc === m_pc[k]) else begin fails++; $error("FAIL pc w%0d got %h want %h", fw_of(k), opc, m_pc[k]); end
      assert (om === exp_mask(m_pc[k], fw_of(k))) else begin fails++; $error("FAIL mask w%0d got %b want %b", fw_of(k), om, exp_mask(m_pc[k], fw_of(k))); end
      assert (onp === exp_next(m_pc[k], fw_of(k))) else begin fails++; $error("FAIL next w%0d got %h want %h", fw_of(k), onp, exp_next(m_pc[k], fw_of(k))); end
      assert (oep === m_ep[k]) else begin fails++; $error("FAIL epoch w%0d got %0d want %0d", fw_of(k), oep, m_ep[k]); end
      assert (ord === m_red[k]) else begin fails++; $error("FAIL redirect w%0d got %0b want %0b", fw_of(k), ord, m_red[k]); end
    end
  endtask

  task automatic step();
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    vectors++;
    assert (got === want) else begin fails++; $error("FAIL %s got %h want %h", tag, got, want); end
  endtask

  task automatic clear_req();
    flush_valid = 0; br_valid = 0; pred_valid = 0; halt = 0; resume = 0;
  endtask

  initial begin
    rst = 1; ready = 1; clear_req();
    flush_pc = '0; br_target = '0; pred_target = '0; flush_id = '0;
    #2;
    step(); step();
    chk("rst_valid", 64'(v2), 64'd0);
    chk("rst_pc", pc2, RV);
    chk("rst_mask", 64'(mask2), 64'd3);
    chk("rst_next", np2, RV + 64'd8);
    chk("rst_next4", np4, RV + 64'd16);

    rst = 0;
    chk("boot_valid", 64'(v2), 64'd0);
    step();
    chk("run_valid", 64'(v2), 64'd1);
    chk("run_pc0", pc2, 64'h8000_0000);
    step();
    chk("run_pc1", pc2, 64'h8000_0008);
    step();
    chk("run_pc2", pc2, 64'h8000_0010);

    ready = 0;
    step(); step(); step();
    chk("stall_pc", pc2, 64'h8000_0010);
    chk("stall_valid", 64'(v2), 64'd1);
    ready = 1;

    br_valid = 1; br_target = 64'h8000_0104;
    step(); clear_req();
    chk("br_pc", pc2, 64'h8000_0104);
    chk("br_mask", 64'(mask2), 64'd2);
    chk("br_next", np2, 64'h8000_0108);
    chk("br_epoch", 64'(ep2), 64'd1);
    chk("br_redirect", 64'(rd2), 64'd1);

    br_valid = 1; br_target = 64'h8000_020C;
    step(); clear_req();
    chk("w4_mask", 64'(mask4), 64'h8);
    chk("w4_next", np4, 64'h8000_0210);

    flush_valid = 1; flush_pc = 64'h9000_0000; flush_id = 4'd5;
    br_valid = 1; br_target = 64'h100; pred_valid = 1; pred_target = 64'h200;
    step(); clear_req();
    chk("prio_flush_pc", pc2, 64'h9000_0000);
    chk("prio_flush_ep", 64'(ep2), 64'd5);
    br_valid = 1; pred_valid = 1;
    step(); clear_req();
    chk("prio_br_pc", pc2, 64'h100);
    chk("prio_br_ep", 64'(ep2), 64'd6);

    flush_valid = 1; flush_pc = 64'hFFFF_FFFF_FFFF_FFF8; flush_id = 4'd0;
    step(); clear_req();
    step();
    chk("wrap_pc", pc2, 64'd0);
    chk("wrap_mask", 64'(mask2), 64'd3);

    halt = 1;
    step(); clear_req();
    chk("halt_valid", 64'(v2), 64'd0);
    pred_valid = 1; pred_target = 64'h4000;
    step(); clear_req();
    chk("halt_pred_valid", 64'(v2), 64'd0);
    resume = 1;
    step(); clear_req();
    chk("resume_valid", 64'(v2), 64'd1);
    chk("resume_pc", pc2, 64'h4000);
    chk("resume_ep", 64'(ep2), 64'd0);

    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      flush_valid = ($urandom_range(0, 11) == 0);
      br_valid    = ($urandom_range(0, 7) == 0);
      pred_valid  = ($urandom_range(0, 5) == 0);
      halt        = ($urandom_range(0, 15) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      ready       = ($urandom_range(0, 3) != 0);
      flush_id    = 4'($urandom);
      flush_pc    = {32'($urandom), 32'($urandom)};
      br_target   = ($urandom_range(0, 7) == 0) ? {32'hFFFF_FFFF, 32'($urandom) | 32'hFFFF_FF00}
                                                : {32'd0, 32'($urandom)};
      pred_target = {32'd0, 32'($urandom)};
      step();
    end
    rst = 0; clear_req();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch PC generator for the instruction-fetch front end. It produces one fetch bundle address per accepted cycle, with a lane-valid mask for bundles that start at an unaligned PC, and a registered epoch tag. It arbitrates three redirect sources: backend flush, execute branch resolution and IF2 predictor. It also supports a debug halt/resume mode and a valid/ready handshake toward the L1 I-cache.

## Interface
- `XLEN`, 64: address width.
- `FETCH_WIDTH`, 2: instructions per bundle; power of two, ≥1.
- `INSTR_BYTES`, 4: bytes per instruction slot; power of two.
- `EPOCH_W`, 4: epoch tag width.
- `RESET_VECTOR`, 64'h0000_0000_8000_0000: must be aligned to bundle bytes B = FETCH_WIDTH*INSTR_BYTES.
- `clk` in 1: single clock; all state on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `flush_valid_i` in 1: backend flush request. Highest priority.
- `flush_pc_i` in XLEN: flush target.
- `flush_id_i` in EPOCH_W: epoch to adopt on flush.
- `br_valid_i` in 1: execute-stage mispredict redirect.
- `br_target_i` in XLEN: branch target.
- `pred_valid_i` in 1: IF2 predictor redirect. Lowest redirect priority.
- `pred_target_i` in XLEN: predicted target.
- `halt_i` in 1: debug halt request.
- `resume_i` in 1: debug resume.
- `fetch_ready_i` in 1: I-cache accepts bundle.
- `fetch_valid_o` out 1: bundle address valid.
- `fetch_pc_o` out XLEN: PC of first valid lane.
- `fetch_mask_o` out FETCH_WIDTH: lane i valid.
- `fetch_epoch_o` out EPOCH_W: current epoch.
- `next_pc_o` out XLEN: aligned PC of the following sequential bundle.
- `redirect_o` out 1: registered pulse; a redirect took effect last cycle.

## Operation
- Redirect targets: clear the low log2(INSTR_BYTES) bits before storing.
- Bundle alignment:
  - aligned base = pc & ~(B-1).
  - off = pc[log2(B)-1 : log2(INSTR_BYTES)].
  - fetch_mask_o[i] = (i ≥ off).
  - next_pc_o = base + B, modulo 2^XLEN (wraps to 0).
- fire = fetch_valid_o & fetch_ready_i.
- Redirect priority: flush > br > pred. Exactly one is applied per cycle; the others are dropped.
  - flush: pc ← flush_pc_i, epoch ← flush_id_i.
  - br: pc ← br_target_i, epoch ← epoch+1 (wraps).
  - pred: pc ← pred_target_i, epoch unchanged.
- Without a redirect: on fire, pc ← next_pc_o. Otherwise pc and all outputs hold stable.
- A redirect overrides fire. A bundle presented in the redirect cycle is not replayed; downstream discards it by epoch or by predictor kill.
- FSM states:
  - BOOT: entered on rst. fetch_valid_o=0. Goes to RUN after exactly one cycle.
  - RUN: fetch_valid_o=1. halt_i → HALT.
  - HALT: fetch_valid_o=0. Redirects still update pc and epoch; the FSM stays in HALT. resume_i → RUN at the held pc.
- halt_i and a redirect in the same RUN cycle: redirect applied and HALT entered.
- halt_i and resume_i together in HALT: resume wins.
- halt_i and resume_i are ignored in BOOT.
- rst mid-operation: the FSM returns to BOOT and all registers return to reset values regardless of other inputs.

## Timing
- Reset values:
  - fetch_valid_o=0.
  - fetch_pc_o=RESET_VECTOR.
  - fetch_mask_o=all ones.
  - next_pc_o=RESET_VECTOR+B.
  - fetch_epoch_o=0.
  - redirect_o=0.
- fetch_valid_o rises on the second clock edge after rst deasserts (one BOOT cycle).
- Redirect and advance latency: 1 cycle. A redirect sampled at edge N appears on fetch_pc_o after edge N, and redirect_o=1 for that following cycle.
- fetch_pc_o, fetch_epoch_o, fetch_valid_o and redirect_o are flop outputs.
- fetch_mask_o and next_pc_o are combinational from the pc register only; there is no input-to-output combinational path.

## Structure
- `fetch_pkg` holds:
  - `pcgen_state_e` (BOOT, RUN, HALT).
  - `redirect_src_e` (NONE, FLUSH, BR, PRED).
  - `FETCH_RESET_VECTOR` constant.
- Sub-module `fetch_lane_mask`: combinational; inputs pc and the parameters; outputs the mask and aligned base. It is reused later by the IF2 predecoder.

## Test plan
- Reset, then fetch_ready_i=1:
  - 1 cycle valid=0.
  - Then pc=0x8000_0000, mask=2'b11, next=0x8000_0008.
  - Then 0x8000_0008, then 0x8000_0010.
- fetch_ready_i=0 for 3 cycles at pc 0x8000_0010: pc, mask and epoch stable; valid stays 1.
- br_valid_i with target 0x8000_0104: next cycle pc=0x8000_0104, mask=2'b10, next=0x8000_0108, epoch 0→1, redirect_o=1.
- Same cycle: flush (0x9000_0000, id 5), br (0x100) and pred (0x200): pc=0x9000_0000, epoch=5. Repeat with only br+pred: br wins.
- pc 0xFFFF_FFFF_FFFF_FFF8 with fire: wraps to pc=0, mask=2'b11.
- halt_i in RUN: valid=0 next cycle. pred redirect to 0x4000 while halted: no valid. resume_i: valid=1, pc=0x4000, epoch unchanged.
- Rerun the redirect test with FETCH_WIDTH=4 and target 0x...0C: mask=4'b1000, next=base+16.
